fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the decode datapath (register read, immediate generation, control decode).
- Owns the PC and issues in-order requests to the instruction memory port.
- Buffers returned words with their PCs in a small queue and hands them to decode over a valid/ready handshake.
- Handles redirects from execute (branch/jump) by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of first fetch after reset.
- QDEPTH, 2, instruction queue entries (power of two, ≥2).
- MAX_OUTST, 2, maximum outstanding memory requests (≤ QDEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after grant.
- imem_rdata  in  XLEN  instruction word.
- redirect_valid  in  1  PC redirect from execute.
- redirect_pc  in  XLEN  redirect target.
- id_valid  out  1  queue head valid to decode.
- id_instr  out  XLEN  head instruction; NOP_INSTR when id_valid=0.
- id_pc  out  XLEN  PC of head instruction.
- id_ready  in  1  decode accepts head (pop when id_valid & id_ready).

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Queue empty; outst=0; drop=0.
  - imem_req=0, id_valid=0, id_instr=NOP_INSTR, id_pc=RESET_PC.
  - First imem_req in the first cycle after release.
- Credit rule: imem_req = !redirect_valid & (outst < MAX_OUTST) & (outst + count < QDEPTH). Guarantees every response has a queue slot; no response is ever back-pressured.
- Request:
  - imem_addr = fetch_pc.
  - On imem_req & imem_gnt: fetch_pc += 4 (wraps at 2^XLEN), outst += 1.
  - imem_req may drop without a grant; no hold requirement.
- Response:
  - On imem_rvalid: outst -= 1.
  - If drop>0: drop -= 1, word discarded.
  - Otherwise push {imem_rdata, resp_pc}; resp_pc += 4.
  - Same-cycle grant and rvalid leave outst unchanged.
- Pop: on id_valid & id_ready, advance head. Same-cycle push and pop on a full queue is legal and keeps count unchanged. Push and pop on an empty queue: the word is not bypassed; it appears on id_* next cycle (queue latency 1).
- Redirect (cycle T, highest priority):
  - Next cycle: fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}; queue count=0.
  - drop = outst_T − (imem_rvalid_T ? 1 : 0). Any response in cycle T is discarded regardless of drop.
  - imem_req=0 in cycle T. id_valid may still be 1 in T; a pop in T is ignored by the flush.
  - Back-to-back redirects: the later target wins, and drop is recomputed from the live outstanding count.
  - Requests issue from the new PC at T+1 subject to credit, even while drop>0.
- Latency: redirect at T → imem_req with the target at T+1. With a 1-cycle memory, the target is on id_* at T+3.
- rvalid with outst==0 is a protocol error: ignore the word and fire the assertion.
- Counter widths: $clog2(MAX_OUTST+1) and $clog2(QDEPTH+1).
- Assertions:
  - count ≤ QDEPTH, outst ≤ MAX_OUTST, drop ≤ outst.
  - imem_addr[1:0]==0.
  - No push when the queue is full.

Decomposition:
- riscv_pkg additions:
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default constant.
  - Typedef fetch_entry_t {instr, pc}.
- Sub-module fetch_queue: parameterised circular buffer of fetch_entry_t with push, pop, flush, count, head outputs, and pointer wrap.
- The top holds the PC, credit, outstanding and drop logic.

Test Plan:
- Reset release, 1-cycle memory returning addr-tagged words, id_ready=1 → imem_addr 0x0,0x4,0x8…; id_pc/id_instr in order; one instruction per cycle in steady state.
- id_ready=0 for 10 cycles → at most QDEPTH words queued, imem_req=0 once credit is exhausted. Release → 0x0,0x4,0x8 delivered, none lost or duplicated.
- Redirect to 0x0000_0103 with 2 outstanding → next imem_addr=0x100; both stale responses dropped; first id_pc=0x100.
- Redirect in the same cycle as rvalid and a pop → that word dropped, queue empty next cycle, drop = outst−1.
- Redirect to 0x200 then to 0x300 one cycle later → only 0x300-stream instructions reach decode.
- fetch_pc 0xFFFF_FFFC → next imem_addr 0x0000_0000. Assert rst_n mid-burst → all outputs return to reset values asynchronously; in-flight responses after release are ignored and flagged.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_MASK        = ~XLEN'(3);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched words with their PCs; flush empties it in one cycle.
module fetch_queue
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;
  logic          do_push;
  fetch_entry_t  mem_q [DEPTH];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ~flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (count_q <= CW'(DEPTH));
      assert (!(do_push && (count_q == CW'(DEPTH)) && !do_pop));
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues credit-limited imem requests and
// buffers responses for decode; redirects flush and drop stale responses.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH    = 2,
  parameter int unsigned     MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int unsigned OW = $clog2(MAX_OUTST+1);
  localparam int unsigned CW = $clog2(QDEPTH+1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   q_count;
  logic            q_valid;
  fetch_entry_t    q_head;
  fetch_entry_t    q_entry;
  logic            grant;
  logic            rsp_ok;
  logic            push;

  // Credit covers both in-flight words and queued words, so a response
  // always finds a free slot and never needs back-pressure.
  always_comb begin
    imem_req = rst_n & ~redirect_valid
             & (32'(outst_q) < MAX_OUTST)
             & ((32'(outst_q) + 32'(q_count)) < QDEPTH);
    grant    = imem_req & imem_gnt;
    rsp_ok   = imem_rvalid & (outst_q != '0);
    push     = rsp_ok & ~redirect_valid & (drop_q == '0);
    outst_d  = outst_q + OW'(grant) - OW'(rsp_ok);

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      resp_pc_d  = word_align(redirect_pc);
      drop_d     = outst_q - OW'(rsp_ok);
    end else begin
      if (grant)                   fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)                    resp_pc_d  = resp_pc_q + XLEN'(4);
      if (rsp_ok && drop_q != '0)  drop_d     = drop_q - OW'(1);
    end

    q_entry.instr = imem_rdata;
    q_entry.pc    = resp_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .entry_i (q_entry),
    .pop_i   (id_valid & id_ready),
    .flush_i (redirect_valid),
    .head_o  (q_head),
    .valid_o (q_valid),
    .count_o (q_count)
  );

  assign imem_addr = fetch_pc_q;
  assign id_valid  = q_valid;
  assign id_instr  = q_valid ? q_head.instr : NOP_INSTR;
  assign id_pc     = q_valid ? q_head.pc : resp_pc_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (32'(outst_q) <= MAX_OUTST);
      assert (drop_q <= outst_q);
      assert (fetch_pc_q[1:0] == 2'b00);
      assert (!(imem_rvalid && outst_q == '0));
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an in-order memory model and a
// scoreboard of PCs expected at decode.
module tb_fetch_sequencer;

  localparam int          QD   = 4;
  localparam int          MO   = 2;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  fetch_sequencer #(
    .RESET_PC  (RPC),
    .QDEPTH    (QD),
    .MAX_OUTST (MO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] fpc;
  int          cyc, lat, last_due, pops;
  int          checks, failures;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic bit rv_due();
    return (pend.size() != 0) && (pend[0].due <= cyc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc);
    pend_t       r;
    bit          rv, req_exp, do_push;
    logic [31:0] push_pc;
    int          due;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rv             = rv_due();
    imem_rvalid    = rv;
    imem_rdata     = rv ? word_of(pend[0].addr) : 32'h0;
    #1;
    chk("id_valid", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("id_pc", id_pc, exp_q[0]);
      chk("id_instr", id_instr, word_of(exp_q[0]));
    end else begin
      chk("id_instr_nop", id_instr, NOP);
    end
    req_exp = !redir && (pend.size() < MO) && (pend.size() + exp_q.size() < QD);
    chk("imem_req", {31'b0, imem_req}, {31'b0, req_exp});
    if (imem_req) chk("imem_addr", imem_addr, fpc);

    do_push = 1'b0;
    push_pc = '0;
    if (rv) begin
      r = pend.pop_front();
      if (!r.stale && !redir) begin
        do_push = 1'b1;
        push_pc = r.addr;
      end
    end
    if (redir) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      fpc = {rpc[31:2], 2'b00};
    end else begin
      if (exp_q.size() != 0 && id_ready) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (do_push) exp_q.push_back(push_pc);
      if (imem_req && imem_gnt) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        pend.push_back('{addr: imem_addr, due: due, stale: 1'b0});
        last_due = due;
        fpc = fpc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'b0, id_valid}, 32'd0);
    chk({tag, "_instr"}, id_instr, NOP);
    chk({tag, "_pc"},    id_pc, RPC);
    chk({tag, "_addr"},  imem_addr, RPC);
  endtask

  initial begin
    bit found;
    int p0;
    checks = 0; failures = 0;
    cyc = 0; lat = 1; last_due = 0; pops = 0;
    fpc = RPC;
    rst_n = 1'b0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

    @(negedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming from reset with a 1-cycle memory.
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    p0 = pops;
    for (int i = 0; i < 8; i++) step(1'b0, '0);
    chk("steady_rate", pops - p0, 32'd8);

    // Decode stalls: queue fills, credit closes, then drains in order.
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    chk("stall_no_req", {31'b0, imem_req}, 32'd0);
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    // Redirect with two requests in flight.
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend.size() == MO) begin found = 1'b1; break; end
      step(1'b0, '0);
    end
    chk("reach_two_outst", {31'b0, found}, 32'd1);
    step(1'b1, 32'h0000_0103);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 10; i++) step(1'b0, '0);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rv_due() && exp_q.size() != 0) begin found = 1'b1; break; end
      step(1'b0, '0);
    end
    chk("reach_rv_pop", {31'b0, found}, 32'd1);
    step(1'b1, 32'h0000_0040);
    chk("flush_empty", {31'b0, id_valid}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0);

    // Back-to-back redirects.
    step(1'b1, 32'h0000_0200);
    step(1'b1, 32'h0000_0300);
    chk("b2b_addr", imem_addr, 32'h0000_0300);
    for (int i = 0; i < 8; i++) step(1'b0, '0);

    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFFC);
    chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fpc == 32'h0) begin found = 1'b1; break; end
      step(1'b0, '0);
    end
    chk("reach_wrap", {31'b0, found}, 32'd1);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step(1'b0, '0);

    // Random grant, ready and latency.
    for (int i = 0; i < 40; i++) begin
      imem_gnt = 1'($urandom_range(0, 1));
      id_ready = 1'($urandom_range(0, 1));
      lat      = int'($urandom_range(1, 3));
      step(1'b0, '0);
    end
    imem_gnt = 1'b1; id_ready = 1'b1; lat = 3;
    for (int i = 0; i < 3; i++) step(1'b0, '0);

    // Asynchronous reset mid-burst; in-flight words arrive while held in reset.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      imem_rvalid = (pend.size() != 0);
      imem_rdata  = (pend.size() != 0) ? word_of(pend[0].addr) : 32'h0;
      if (pend.size() != 0) void'(pend.pop_front());
      #1 chk("in_rst_valid", {31'b0, id_valid}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    imem_rvalid = 1'b0;
    pend.delete();
    exp_q.delete();
    fpc = RPC;
    lat = 1;
    last_due = cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
